alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one IntegerALU instance between two requesters (e.g. the integer pipe and the address/branch helper).
- Arbitration is round-robin with a valid/ready handshake on both the request and response sides.
- The ALU result is registered into a per-requester one-entry response buffer, giving fixed 1-cycle latency.
- The block instantiates IntegerALU internally and is its only driver.

Parameters:
- width, 32, datapath width of operands and results, passed to IntegerALU.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  4  IntegerALU opcode for requester 0
- req0_a  in  width  operand A for requester 0
- req0_b  in  width  operand B for requester 0
- resp0_valid  out  1  requester 0 result available
- resp0_ready  in  1  requester 0 consumes result
- resp0_data  out  width  requester 0 result
- req1_valid, req1_ready, req1_op, req1_a, req1_b, resp1_valid, resp1_ready, resp1_data: same as requester 0, for requester 1.

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - resp0_valid = resp1_valid = 0.
  - resp0_data = resp1_data = 0.
  - Priority pointer last_grant = 1, so requester 0 wins the first tie.
  - Reset mid-operation discards buffered results; nothing is replayed.
- Eligibility: elig_i = reqi_valid && (!respi_valid || respi_ready). A requester whose response buffer is full and not draining this cycle cannot be granted.
- Grant (combinational, at most one per cycle):
  - Both eligible: grant the index != last_grant.
  - Exactly one eligible: grant it.
  - None eligible: no grant.
- reqi_ready = grant_i. It may depend combinationally on reqi_valid and respi_ready. Requesters must not make valid depend on ready.
- On the clock edge with grant_i:
  - respi_data <= ALU(reqi_op, reqi_a, reqi_b).
  - respi_valid <= 1.
  - last_grant <= i.
- On a clock edge without grant_i: if respi_valid && respi_ready then respi_valid <= 0. respi_data holds its value.
- Simultaneous drain and refill on the same edge: the new result overwrites, valid stays 1. This gives back-to-back throughput of 1 op/cycle per requester when uncontended.
- Latency: request accepted at edge N, response visible after edge N, i.e. resp valid in cycle N+1.
- last_grant changes only on a grant. Idle cycles preserve fairness state.
- ALU semantics (IntegerALU opcode map):
  - 0000 add; 0001 sub.
  - 001x sll.
  - 010x slt (signed); 011x sltu. Both results zero-extended to width, value 0 or 1.
  - 100x xor.
  - 1010 srl; 1011 sra.
  - 110x or; 111x and.
  - Shift amount is B[$clog2(width)-1:0]; upper B bits are ignored.
  - All add/sub arithmetic is modulo 2^width.
- Request operands are sampled only on the granting edge. They may change freely otherwise.
- Starvation bound: a continuously eligible requester is granted within 2 cycles.

Test Plan:
- Uncontended add: after reset, req0_valid=1, op=0000, A=5, B=7, resp0_ready=1 → req0_ready=1 that cycle; next cycle resp0_valid=1, resp0_data=0x0000000C; one cycle later resp0_valid=0 with req0_valid=0.
- Tie after reset: req0 (op 0001, A=3, B=5) and req1 (op 1011, A=0x80000000, B=4) valid together, both resp_ready=1 → cycle 1 grants req0, resp0_data=0xFFFFFFFE; cycle 2 grants req1, resp1_data=0xF8000000; continued assertion alternates 0,1,0,1.
- Backpressure: resp0_valid=1, resp0_ready=0, req0_valid=1, req1_valid=1 → req0_ready=0 and req1 granted every cycle; raising resp0_ready → req0 granted that same cycle (if last_grant=1), resp0_valid stays 1 with new data.
- Opcode sweep on requester 1 with A=0xFFFFFFFF, B=0x00000001 and B=0x24:
  - slt → 1; sltu → 0.
  - srl with B=0x24 → 0x0FFFFFFF (shift 4).
  - sll with B=0x24 → 0xFFFFFFF0.
  - xor → 0xFFFFFFFE; and → 0x00000001; or → 0xFFFFFFFF.
- Async reset mid-operation: pull rst_n low between clock edges while resp0_valid=1 and resp1_valid=1 → both valid and data go to 0 immediately. After release, a tie grants requester 0 first.
- Random soak: 1000 cycles, random valid/ready/op/operands against a reference model → every accepted op yields exactly one matching response, and no grant is made while that requester's buffer is full and not draining.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for a single shared IntegerALU.
// Each requester owns a one-entry registered response buffer, so an accepted
// operation is visible on its response port exactly one cycle later.

// Combinational integer ALU shared by both requesters.
module IntegerALU #(
  parameter int width = 32
) (
  input  logic [3:0]       op,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] y
);

  localparam int SHW = $clog2(width);

  logic [SHW-1:0] shamt_s;
  logic           lt_signed_s;
  logic           lt_unsigned_s;

  assign shamt_s       = b[SHW-1:0];
  assign lt_signed_s   = ($signed(a) < $signed(b));
  assign lt_unsigned_s = (a < b);

  // Opcode decode; bit 0 only matters for add/sub and srl/sra.
  always_comb begin
    y = {width{1'b0}};
    case (op[3:1])
      3'b000: begin
        if (op[0]) begin
          y = a - b;
        end else begin
          y = a + b;
        end
      end
      3'b001: y = a << shamt_s;
      3'b010: y = {{(width-1){1'b0}}, lt_signed_s};
      3'b011: y = {{(width-1){1'b0}}, lt_unsigned_s};
      3'b100: y = a ^ b;
      3'b101: begin
        // Kept as separate branches so the arithmetic shift stays signed.
        if (op[0]) begin
          y = $unsigned($signed(a) >>> shamt_s);
        end else begin
          y = a >> shamt_s;
        end
      end
      3'b110: y = a | b;
      3'b111: y = a & b;
      default: y = {width{1'b0}};
    endcase
  end

endmodule

module alu_share_arbiter #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [width-1:0] req0_a,
  input  logic [width-1:0] req0_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [width-1:0] resp0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [width-1:0] req1_a,
  input  logic [width-1:0] req1_b,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [width-1:0] resp1_data
);

  logic             elig0_s;
  logic             elig1_s;
  logic             grant0_s;
  logic             grant1_s;
  logic [3:0]       alu_op_s;
  logic [width-1:0] alu_a_s;
  logic [width-1:0] alu_b_s;
  logic [width-1:0] alu_y_s;

  logic             resp0_valid_d, resp0_valid_q;
  logic             resp1_valid_d, resp1_valid_q;
  logic [width-1:0] resp0_data_d,  resp0_data_q;
  logic [width-1:0] resp1_data_d,  resp1_data_q;
  logic             last_grant_d,  last_grant_q;

  // A full buffer can only take a new result if it drains on the same edge.
  assign elig0_s = req0_valid && (!resp0_valid_q || resp0_ready);
  assign elig1_s = req1_valid && (!resp1_valid_q || resp1_ready);

  // Round-robin pick: on a tie the requester not served last wins.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (elig0_s && elig1_s) begin
      if (last_grant_q) begin
        grant0_s = 1'b1;
      end else begin
        grant1_s = 1'b1;
      end
    end else if (elig0_s) begin
      grant0_s = 1'b1;
    end else if (elig1_s) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // Steer the granted requester's operands into the single ALU.
  always_comb begin
    alu_op_s = req0_op;
    alu_a_s  = req0_a;
    alu_b_s  = req0_b;
    if (grant1_s) begin
      alu_op_s = req1_op;
      alu_a_s  = req1_a;
      alu_b_s  = req1_b;
    end else begin
      alu_op_s = req0_op;
      alu_a_s  = req0_a;
      alu_b_s  = req0_b;
    end
  end

  IntegerALU #(.width(width)) u_alu (
    .op (alu_op_s),
    .a  (alu_a_s),
    .b  (alu_b_s),
    .y  (alu_y_s)
  );

  // Buffer and fairness next-state: refill wins over drain; idle keeps pointer.
  always_comb begin
    resp0_valid_d = resp0_valid_q;
    resp0_data_d  = resp0_data_q;
    resp1_valid_d = resp1_valid_q;
    resp1_data_d  = resp1_data_q;
    last_grant_d  = last_grant_q;

    if (grant0_s) begin
      resp0_valid_d = 1'b1;
      resp0_data_d  = alu_y_s;
    end else if (resp0_valid_q && resp0_ready) begin
      resp0_valid_d = 1'b0;
    end else begin
      resp0_valid_d = resp0_valid_q;
    end

    if (grant1_s) begin
      resp1_valid_d = 1'b1;
      resp1_data_d  = alu_y_s;
    end else if (resp1_valid_q && resp1_ready) begin
      resp1_valid_d = 1'b0;
    end else begin
      resp1_valid_d = resp1_valid_q;
    end

    if (grant0_s) begin
      last_grant_d = 1'b0;
    end else if (grant1_s) begin
      last_grant_d = 1'b1;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // State registers; reset empties both buffers and favours requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_data_q  <= {width{1'b0}};
      resp1_data_q  <= {width{1'b0}};
      last_grant_q  <= 1'b1;
    end else begin
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_data_q  <= resp0_data_d;
      resp1_data_q  <= resp1_data_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp0_data  = resp0_data_q;
  assign resp1_data  = resp1_data_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench: expected results are queued when an operation is
// accepted and popped by a monitor when the response is consumed.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, resp0_valid, resp0_ready;
  logic        req1_valid, req1_ready, resp1_valid, resp1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, resp0_data, resp1_data;
  logic [31:0] exp0, exp1;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          n_cmp;
  int          n_err;
  int          wait0, wait1;

  alu_share_arbiter #(.width(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, expv, $time);
    end
  endfunction

  // Independent reference model of the opcode map.
  function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    int unsigned sh;
    logic [63:0] ext;
    sh = int'(b[4:0]);
    ext = {{32{a[31]}}, a};
    case (op)
      4'h0: return a + b;
      4'h1: return a + (~b) + 32'd1;
      4'h2, 4'h3: return a << sh;
      4'h4, 4'h5: return ((a[31] && !b[31]) || ((a[31] == b[31]) && (a < b))) ? 32'd1 : 32'd0;
      4'h6, 4'h7: return (a < b) ? 32'd1 : 32'd0;
      4'h8, 4'h9: return a ^ b;
      4'hA: return a >> sh;
      4'hB: return ext[31+sh -: 32] & 32'hFFFF_FFFF;
      4'hC, 4'hD: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Monitor: pop on consumption, push on acceptance, check grant protocol.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      wait0 = 0;
      wait1 = 0;
    end else begin
      if (resp0_valid && resp0_ready) begin
        if (q0.size() == 0) chk("resp0_extra", 32'd1, 32'd0);
        else chk("resp0_data", resp0_data, q0.pop_front());
      end
      if (resp1_valid && resp1_ready) begin
        if (q1.size() == 0) chk("resp1_extra", 32'd1, 32'd0);
        else chk("resp1_data", resp1_data, q1.pop_front());
      end
      if (req0_ready) q0.push_back(exp0);
      if (req1_ready) q1.push_back(exp1);
      chk("one_grant", {31'd0, req0_ready && req1_ready}, 32'd0);
      chk("full_grant0", {31'd0, req0_ready && resp0_valid && !resp0_ready}, 32'd0);
      chk("full_grant1", {31'd0, req1_ready && resp1_valid && !resp1_ready}, 32'd0);
      if (req0_valid && (!resp0_valid || resp0_ready)) begin
        if (!req0_ready) wait0 = wait0 + 1; else wait0 = 0;
        chk("starve0", wait0, (wait0 > 1) ? 32'd0 : wait0);
      end else wait0 = 0;
      if (req1_valid && (!resp1_valid || resp1_ready)) begin
        if (!req1_ready) wait1 = wait1 + 1; else wait1 = 0;
        chk("starve1", wait1, (wait1 > 1) ? 32'd0 : wait1);
      end else wait1 = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 4'h0; req1_op = 4'h0;
    req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
    exp0 = 32'd0; exp1 = 32'd0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    idle();
    #1;
    chk("rst_v0", {31'd0, resp0_valid}, 32'd0);
    chk("rst_v1", {31'd0, resp1_valid}, 32'd0);
    chk("rst_d0", resp0_data, 32'd0);
    chk("rst_d1", resp1_data, 32'd0);
    @(posedge clk); #6;
    rst_n = 1'b1;
    step();
  endtask

  logic [3:0]  sw_op [15];
  logic [31:0] sw_b  [15];
  logic [31:0] sw_e  [15];

  initial begin
    n_cmp = 0; n_err = 0; wait0 = 0; wait1 = 0;
    rst_n = 1'b0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    idle();
    do_reset();

    // Uncontended add
    req0_valid = 1'b1; req0_op = 4'h0; req0_a = 32'd5; req0_b = 32'd7; exp0 = 32'h0000_000C;
    #1 chk("t1_ready", {31'd0, req0_ready}, 32'd1);
    step(); idle();
    chk("t1_valid", {31'd0, resp0_valid}, 32'd1);
    chk("t1_data", resp0_data, 32'h0000_000C);
    step();
    chk("t1_drained", {31'd0, resp0_valid}, 32'd0);

    // Tie after reset, then alternation
    do_reset();
    req0_valid = 1'b1; req0_op = 4'h1; req0_a = 32'd3; req0_b = 32'd5; exp0 = 32'hFFFF_FFFE;
    req1_valid = 1'b1; req1_op = 4'hB; req1_a = 32'h8000_0000; req1_b = 32'd4; exp1 = 32'hF800_0000;
    #1 chk("t2_g0", {30'd0, req1_ready, req0_ready}, 32'd1);
    step();
    chk("t2_d0", resp0_data, 32'hFFFF_FFFE);
    chk("t2_g1", {30'd0, req1_ready, req0_ready}, 32'd2);
    step();
    chk("t2_d1", resp1_data, 32'hF800_0000);
    chk("t2_g2", {30'd0, req1_ready, req0_ready}, 32'd1);
    step();
    chk("t2_g3", {30'd0, req1_ready, req0_ready}, 32'd2);
    step(); idle(); step(); step();

    // Backpressure on requester 0
    resp0_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 4'h0; req0_a = 32'd1; req0_b = 32'd1; exp0 = 32'd2;
    step();
    req1_valid = 1'b1; req1_op = 4'h0; req1_a = 32'd10; req1_b = 32'd20; exp1 = 32'd30;
    #1 chk("t3_g_a", {30'd0, req1_ready, req0_ready}, 32'd2);
    step();
    chk("t3_g_b", {30'd0, req1_ready, req0_ready}, 32'd2);
    chk("t3_held", resp0_data, 32'd2);
    step();
    resp0_ready = 1'b1; req0_a = 32'd100; exp0 = 32'd101;
    #1 chk("t3_g_c", {30'd0, req1_ready, req0_ready}, 32'd1);
    step();
    chk("t3_v", {31'd0, resp0_valid}, 32'd1);
    chk("t3_d", resp0_data, 32'd101);
    idle(); step(); step();

    // Opcode sweep on requester 1, A = all ones
    sw_op = '{4'h4, 4'h6, 4'hA, 4'h2, 4'h8, 4'hE, 4'hC, 4'hB, 4'h0, 4'h1, 4'h5, 4'h3, 4'hF, 4'hD, 4'h9};
    sw_b  = '{32'h1, 32'h1, 32'h24, 32'h24, 32'h1, 32'h1, 32'h1, 32'h24, 32'h1, 32'h1,
              32'h1, 32'h1, 32'h1, 32'h1, 32'h1};
    sw_e  = '{32'h1, 32'h0, 32'h0FFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFF,
              32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFF,
              32'hFFFF_FFFE};
    for (int k = 0; k < 15; k++) begin
      req1_valid = 1'b1; req1_op = sw_op[k]; req1_a = 32'hFFFF_FFFF; req1_b = sw_b[k]; exp1 = sw_e[k];
      step();
      chk($sformatf("sweep_op%h", sw_op[k]), resp1_data, sw_e[k]);
    end
    idle(); step(); step();

    // Async reset with both buffers full
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 4'h0; req0_a = 32'd9; req0_b = 32'd9; exp0 = 32'd18;
    req1_valid = 1'b1; req1_op = 4'hC; req1_a = 32'hF0; req1_b = 32'h0F; exp1 = 32'hFF;
    step(); step(); idle();
    chk("t5_full", {30'd0, resp1_valid, resp0_valid}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_v", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    chk("t5_d0", resp0_data, 32'd0);
    chk("t5_d1", resp1_data, 32'd0);
    @(posedge clk); #6 rst_n = 1'b1;
    step();
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; exp0 = 32'd0; exp1 = 32'd0;
    #1 chk("t5_tie", {30'd0, req1_ready, req0_ready}, 32'd1);
    step(); idle(); step(); step();

    // Random soak
    for (int c = 0; c < 1000; c++) begin
      req0_valid = ($urandom_range(3) != 0);
      req1_valid = ($urandom_range(3) != 0);
      resp0_ready = ($urandom_range(2) != 0);
      resp1_ready = ($urandom_range(2) != 0);
      req0_op = 4'($urandom_range(15)); req1_op = 4'($urandom_range(15));
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      exp0 = ref_alu(req0_op, req0_a, req0_b);
      exp1 = ref_alu(req1_op, req1_a, req1_b);
      step();
    end
    idle(); resp0_ready = 1'b1; resp1_ready = 1'b1;
    step(); step(); step();
    chk("q0_empty", q0.size(), 32'd0);
    chk("q1_empty", q1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
